mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
// Shares one 64x64 multiplier between NREQ requesters; each op selects signed (TC) or unsigned (US).
// Round-robin arbitration over valid/ready request ports feeds a LAT-stage registered multiply pipeline.
// Results return in order on one tagged response port with backpressure.
// Sits between the execution clients and the multiplier datapath.
// PARAMETERS
// NREQ  2   number of requesters; legal range 2..8
// LAT   2   accept-to-response latency in cycles, >=1; number of pipeline stages
// IDW   $clog2(NREQ)  requester tag width; derived, not overridable
// PORTS
// clk          in   1          clock, rising edge
// reset        in   1          synchronous, active-low reset
// req_valid    in   NREQ       per-requester request valid
// req_signed   in   NREQ       1 = two's-complement op, 0 = unsigned op
// req_a        in   NREQ*64    operand A, packed, requester i at [64*i +: 64]
// req_b        in   NREQ*64    operand B, packed as req_a
// req_ready    out  NREQ       one-hot grant; accept = req_valid[i] & req_ready[i]
// rsp_valid    out  1          response valid
// rsp_ready    in   1          response consumer ready
// rsp_id       out  IDW        requester index of the response
// rsp_signed   out  1          signedness of the responding op
// rsp_result   out  128        full 128-bit product
// busy         out  1          any op in flight (any stage valid)
// ops_done     out  32         count of responses handed off (rsp_valid & rsp_ready); wraps at 2^32
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - all stage valids, rsp_valid, rsp_id, rsp_signed, rsp_result, busy and ops_done <= 0.
//   - rr_ptr <= 0.
//   - In-flight ops are discarded and never responded to.
// - Stall: stall = rsp_valid & ~rsp_ready.
//   - While stalled, every pipeline stage holds and req_ready = 0.
//   - rsp_* outputs stay stable until the handshake completes.
// - Arbitration, when not stalled:
//   - Scan requesters from rr_ptr upward (mod NREQ); the first with req_valid set gets req_ready = 1.
//   - All other req_ready bits are 0; if no requester is valid, req_ready = 0.
//   - req_ready is combinational from req_valid, rr_ptr and stall.
//   - On accept by requester g: rr_ptr <= (g+1) mod NREQ. rr_ptr is unchanged when nothing is accepted.
//   - Fairness: with all requesters continuously valid, each is granted exactly once per NREQ consecutive accepts.
// - Requester rule: once raised, valid, operands and signed must hold until accepted.
//   The block does not check this rule.
// - Datapath:
//   - On accept, stage 1 captures {valid=1, id=g, signed, product}.
//   - Signed op: product = sext(a) * sext(b), 128-bit TC result.
//   - Unsigned op: product = zext(a) * zext(b).
//   - Stages 2..LAT shift forward each unstalled cycle; the last stage drives rsp_*.
//   - Latency: accepted at edge t gives rsp_valid=1 after edge t+LAT-1, with no stall.
//   - Throughput: 1 op per cycle.
//   - A bubble (no accept) shifts in as valid=0 and does not reset data regs.
// - Ordering: responses leave strictly in accept order; no reordering and no drops except on reset.
// - Simultaneous events:
//   - Handshake in the same cycle as a new accept: both happen and the pipeline advances.
//   - A stall starting in the cycle an accept is requested blocks the accept (ready=0).
// - busy = OR of all stage valid bits, including the output stage.
// - ops_done increments by 1 on each rsp_valid & rsp_ready edge; 0xFFFFFFFF+1 -> 0.
// TESTING
// 1. Unsigned: req0 a=FFFFFFFFFFFFFFFF, b=2, signed=0, rsp_ready=1
//    -> rsp after LAT cycles, result=0x1_FFFFFFFFFFFFFFFE, rsp_id=0, ops_done=1.
// 2. Signed: req1 a=FFFFFFFFFFFFFFFF (-1), b=2, signed=1
//    -> result=0xFFFF...FFFE (128-bit -2), rsp_id=1, rsp_signed=1.
// 3. Signed corner: a=8000000000000000, b=FFFFFFFFFFFFFFFF, signed=1
//    -> 0x0000000000000000_8000000000000000.
// 4. Fairness: both requesters held valid for 6 accepts after reset
//    -> grant order 0,1,0,1,0,1; responses in the same order; 1 accept per cycle.
// 5. Backpressure: 3 ops in flight, rsp_ready=0 for 3 cycles
//    -> rsp_* stable, req_ready=0, all 3 results later delivered in order, ops_done=3.
// 6. Reset mid-flight: reset=0 for 1 cycle with 2 ops in flight
//    -> next cycle rsp_valid=0, busy=0, ops_done=0, dropped ops never appear, next grant starts at req0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin shares one 64x64 multiplier (signed or
// unsigned per op) between NREQ requesters. Accepted ops flow through a
// LAT-stage registered pipeline and return in accept order on a single
// tagged response port with backpressure.
module mul_share_arbiter #(
  parameter  int unsigned NREQ = 2,
  parameter  int unsigned LAT  = 2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_signed,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_signed,
  output logic [127:0]         rsp_result,
  output logic                 busy,
  output logic [31:0]          ops_done
);

  localparam int unsigned OPW = 64;
  localparam int unsigned PW  = 2 * OPW;

  logic            w_stall;
  logic            w_found;
  logic [IDW-1:0]  w_gidx;
  logic [IDW-1:0]  w_ptr_nxt;
  logic            w_gsgn;
  logic [OPW-1:0]  w_ga;
  logic [OPW-1:0]  w_gb;
  logic [PW-1:0]   w_ga_ext;
  logic [PW-1:0]   w_gb_ext;
  logic [PW-1:0]   w_prod;
  logic            w_busy_nxt;
  int unsigned     w_scan;

  logic [IDW-1:0]  r_rr_ptr;
  logic            r_vld  [LAT];
  logic [IDW-1:0]  r_id   [LAT];
  logic            r_sgn  [LAT];
  logic [PW-1:0]   r_prod [LAT];
  logic            r_busy;
  logic [31:0]     r_ops_done;

  // A response held at the output without a taker freezes the whole pipe.
  assign w_stall = r_vld[LAT-1] & ~rsp_ready;

  // Round-robin scan from r_rr_ptr upward; first valid requester wins.
  always_comb begin
    w_found   = 1'b0;
    w_gidx    = '0;
    w_scan    = 0;
    req_ready = '0;
    if (!w_stall) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        w_scan = 32'(r_rr_ptr) + k;
        if (w_scan >= NREQ) begin
          w_scan = w_scan - NREQ;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!w_found && (w_scan == i) && req_valid[i]) begin
            w_found      = 1'b1;
            w_gidx       = IDW'(i);
            req_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  // Select the granted requester's operands and signedness.
  always_comb begin
    w_ga   = '0;
    w_gb   = '0;
    w_gsgn = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gidx == IDW'(i)) begin
        w_ga   = req_a[i*OPW +: OPW];
        w_gb   = req_b[i*OPW +: OPW];
        w_gsgn = req_signed[i];
      end
    end
  end

  // Extending to full product width makes a single modular multiply correct
  // for both signed and unsigned operands.
  assign w_ga_ext = w_gsgn ? {{OPW{w_ga[OPW-1]}}, w_ga} : {{OPW{1'b0}}, w_ga};
  assign w_gb_ext = w_gsgn ? {{OPW{w_gb[OPW-1]}}, w_gb} : {{OPW{1'b0}}, w_gb};
  assign w_prod   = w_ga_ext * w_gb_ext;

  assign w_ptr_nxt = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);

  // Occupancy of the pipeline after the coming edge.
  always_comb begin
    w_busy_nxt = 1'b0;
    if (w_stall) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        w_busy_nxt = w_busy_nxt | r_vld[k];
      end
    end else begin
      w_busy_nxt = w_found;
      for (int unsigned k = 0; k + 1 < LAT; k++) begin
        w_busy_nxt = w_busy_nxt | r_vld[k];
      end
    end
  end

  // Multiply pipeline: load stage 0 on accept, shift forward when not stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        r_vld[k]  <= 1'b0;
        r_id[k]   <= '0;
        r_sgn[k]  <= 1'b0;
        r_prod[k] <= '0;
      end
    end else if (!w_stall) begin
      r_vld[0] <= w_found;
      if (w_found) begin
        r_id[0]   <= w_gidx;
        r_sgn[0]  <= w_gsgn;
        r_prod[0] <= w_prod;
      end
      for (int unsigned k = 1; k < LAT; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_id[k]   <= r_id[k-1];
        r_sgn[k]  <= r_sgn[k-1];
        r_prod[k] <= r_prod[k-1];
      end
    end
  end

  // Round-robin pointer, busy flag and handoff counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr   <= '0;
      r_busy     <= 1'b0;
      r_ops_done <= '0;
    end else begin
      if (w_found) begin
        r_rr_ptr <= w_ptr_nxt;
      end
      r_busy <= w_busy_nxt;
      if (r_vld[LAT-1] && rsp_ready) begin
        r_ops_done <= r_ops_done + 32'd1;
      end
    end
  end

  assign rsp_valid  = r_vld[LAT-1];
  assign rsp_id     = r_id[LAT-1];
  assign rsp_signed = r_sgn[LAT-1];
  assign rsp_result = r_prod[LAT-1];
  assign busy       = r_busy;
  assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: transaction-level model (grant rule + FIFO of
// in-flight ops with age counters) checked every cycle, plus directed
// vectors with hand-computed results.
module tb_mul_share_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned LAT  = 2;
  localparam int unsigned IDW  = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_signed;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_signed;
  logic [127:0]       rsp_result;
  logic               busy;
  logic [31:0]        ops_done;

  mul_share_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_signed (rsp_signed),
    .rsp_result (rsp_result),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input bit s);
    logic signed [127:0] ps;
    logic        [127:0] pu;
    if (s) begin
      ps = $signed(a) * $signed(b);
      return ps;
    end
    pu = a * b;
    return pu;
  endfunction

  // Transaction model state
  typedef struct {
    int           id;
    bit           sgn;
    logic [127:0] prod;
    int           age;
  } op_t;

  op_t          mq[$];
  int           m_ptr = 0;
  logic [31:0]  m_cnt = '0;
  bit           m_armed = 1'b0;
  logic [127:0] rsp_res_log[$];
  int           rsp_id_log[$];

  // Per-cycle compare against the model, then advance the model at the edge.
  initial begin : cmp
    bit            vld;
    bit            stl;
    int            g;
    int            idx;
    logic [NREQ-1:0] er;
    logic [63:0]   ga;
    logic [63:0]   gb;
    bit            gs;
    op_t           o;
    ga = '0; gb = '0; gs = 1'b0;
    forever begin
      @(negedge clk);
      vld = 1'b0;
      stl = 1'b0;
      g   = -1;
      if (m_armed) begin
        vld = (mq.size() > 0) && (mq[0].age >= int'(LAT) - 1);
        stl = vld && !rsp_ready;
        if (!stl) begin
          for (int k = 0; k < int'(NREQ); k++) begin
            idx = (m_ptr + k) % int'(NREQ);
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("rsp_valid", 128'(rsp_valid), 128'(vld));
        if (vld) begin
          chk("rsp_id", 128'(rsp_id), 128'(mq[0].id));
          chk("rsp_signed", 128'(rsp_signed), 128'(mq[0].sgn));
          chk("rsp_result", rsp_result, mq[0].prod);
        end
        chk("busy", 128'(busy), 128'(mq.size() > 0));
        chk("ops_done", 128'(ops_done), 128'(m_cnt));
        if (g >= 0) begin
          ga = req_a[g*64 +: 64];
          gb = req_b[g*64 +: 64];
          gs = req_signed[g];
        end
      end
      @(posedge clk);
      if (!reset) begin
        mq.delete();
        m_ptr   = 0;
        m_cnt   = '0;
        m_armed = 1'b1;
      end else if (m_armed && !stl) begin
        if (vld && rsp_ready) begin
          void'(mq.pop_front());
          m_cnt++;
        end
        foreach (mq[i]) mq[i].age++;
        if (g >= 0) begin
          o.id   = g;
          o.sgn  = gs;
          o.prod = ref_mul(ga, gb, gs);
          o.age  = 0;
          mq.push_back(o);
          m_ptr = (g + 1) % int'(NREQ);
        end
      end
    end
  end

  // Record what the DUT actually hands off (handshake completes next edge).
  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rsp_res_log.push_back(rsp_result);
      rsp_id_log.push_back(int'(rsp_id));
    end
  end

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b, input bit s);
    int n;
    n = 0;
    req_valid[i]       = 1'b1;
    req_signed[i]      = s;
    req_a[i*64 +: 64]  = a;
    req_b[i*64 +: 64]  = b;
    @(negedge clk);
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_grant", 128'(req_ready[i]), 128'(1));
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", 128'(rsp_valid), 128'(1));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 128'(busy), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int g;
    reset      = 1'b0;
    req_valid  = '0;
    req_signed = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ops_done", 128'(ops_done), 128'(0));
    @(posedge clk);
    #1;

    // 1: unsigned max * 2
    issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    wait_rsp(n);
    chk("t1_latency", 128'(n), 128'(LAT - 1));
    chk("t1_result", rsp_result, 128'h1_FFFF_FFFF_FFFF_FFFE);
    chk("t1_id", 128'(rsp_id), 128'(0));
    chk("t1_signed", 128'(rsp_signed), 128'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_ops_done", 128'(ops_done), 128'(1));
    @(posedge clk);
    #1;

    // 2: signed -1 * 2
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
    wait_rsp(n);
    chk("t2_result", rsp_result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    chk("t2_id", 128'(rsp_id), 128'(1));
    chk("t2_signed", 128'(rsp_signed), 128'(1));
    @(posedge clk);
    #1;

    // 3: signed most-negative * -1
    issue(0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_rsp(n);
    chk("t3_result", rsp_result, 128'h0000_0000_0000_0000_8000_0000_0000_0000);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_ops_done", 128'(ops_done), 128'(3));
    @(posedge clk);
    #1;

    // 4: fairness with both requesters continuously valid
    do_reset();
    rsp_id_log.delete();
    rsp_res_log.delete();
    req_signed = 2'b10;
    req_a[0 +: 64]  = 64'd10;  req_b[0 +: 64]  = 64'd3;
    req_a[64 +: 64] = 64'd20;  req_b[64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_one_grant", 128'($countones(req_ready)), 128'(1));
      g = req_ready[1] ? 1 : 0;
      chk("t4_grant_order", 128'(g), 128'(k % 2));
      @(posedge clk);
      #1;
      req_a[g*64 +: 64] = req_a[g*64 +: 64] + 64'd1;
    end
    req_valid = '0;
    drain("t4_drain");
    chk("t4_rsp_count", 128'(rsp_id_log.size()), 128'(6));
    for (int k = 0; k < 6; k++) begin
      if (k < rsp_id_log.size()) chk("t4_rsp_order", 128'(rsp_id_log[k]), 128'(k % 2));
    end
    if (rsp_res_log.size() >= 2) begin
      chk("t4_first_res", rsp_res_log[0], 128'd30);
      chk("t4_second_res", rsp_res_log[1], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEC);
    end

    // 5: backpressure with ops stacked behind a held response
    do_reset();
    rsp_res_log.delete();
    rsp_id_log.delete();
    rsp_ready  = 1'b0;
    req_signed = 2'b10;
    req_a[0 +: 64]  = 64'd3;                  req_b[0 +: 64]  = 64'd5;
    req_a[64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFD; req_b[64 +: 64] = 64'd7;
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    req_a[0 +: 64] = 64'h1_0000_0000;
    req_b[0 +: 64] = 64'h1_0000_0000;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", 128'(rsp_valid), 128'(1));
      chk("t5_hold_result", rsp_result, 128'd15);
      chk("t5_hold_id", 128'(rsp_id), 128'(0));
      chk("t5_no_ready", 128'(req_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_resume_grant", 128'(req_ready), 128'(2'b01));
    @(posedge clk);
    #1;
    req_valid = '0;
    drain("t5_drain");
    chk("t5_rsp_count", 128'(rsp_res_log.size()), 128'(3));
    if (rsp_res_log.size() == 3) begin
      chk("t5_res0", rsp_res_log[0], 128'd15);
      chk("t5_res1", rsp_res_log[1], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
      chk("t5_res2", rsp_res_log[2], 128'h1_0000_0000_0000_0000);
    end
    @(negedge clk);
    chk("t5_ops_done", 128'(ops_done), 128'(3));
    @(posedge clk);
    #1;

    // 6: reset with two ops in flight
    req_signed = 2'b00;
    req_a[0 +: 64]  = 64'd6;  req_b[0 +: 64]  = 64'd7;
    req_a[64 +: 64] = 64'd8;  req_b[64 +: 64] = 64'd9;
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req_valid = '0;
    reset     = 1'b0;
    rsp_res_log.delete();
    rsp_id_log.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_ops_done", 128'(ops_done), 128'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_ghost", 128'(rsp_res_log.size()), 128'(0));
    req_valid = 2'b11;
    @(negedge clk);
    chk("t6_first_grant", 128'(req_ready), 128'(2'b01));
    @(posedge clk);
    #1;
    req_valid = '0;
    drain("t6_drain");
    chk("t6_res", (rsp_res_log.size() > 0) ? rsp_res_log[0] : 128'd0, 128'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
